// File: rtl/vram_write_arbiter_if.sv
// Bus bundle between the VRAM write arbiter and its requesters / the CHR_GEN write port.
// The requesting side (CPU bus, test top) uses master; the arbiter uses slave.
interface vram_write_arbiter_if #(
    parameter int C_AW = 10,
    parameter int C_DW = 8
);
    logic            CK_EE_i;
    logic            BLANK_i;
    logic            CPU_REQ_i;
    logic [C_AW-1:0] CPU_WAs_i;
    logic [C_DW-1:0] CPU_WDs_i;
    logic            CPU_ACK_o;
    logic            FILL_START_i;
    logic            FILL_ABORT_i;
    logic [C_DW-1:0] FILL_DATs_i;
    logic            FILL_INC_i;
    logic            FILL_BUSY_o;
    logic            FILL_DONE_o;
    logic [C_AW-1:0] VRAM_WAs_o;
    logic [C_DW-1:0] VRAM_WDs_o;
    logic            VRAM_WE_o;

    modport master (
        output CK_EE_i, BLANK_i, CPU_REQ_i, CPU_WAs_i, CPU_WDs_i,
               FILL_START_i, FILL_ABORT_i, FILL_DATs_i, FILL_INC_i,
        input  CPU_ACK_o, FILL_BUSY_o, FILL_DONE_o,
               VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o
    );

    modport slave (
        input  CK_EE_i, BLANK_i, CPU_REQ_i, CPU_WAs_i, CPU_WDs_i,
               FILL_START_i, FILL_ABORT_i, FILL_DATs_i, FILL_INC_i,
        output CPU_ACK_o, FILL_BUSY_o, FILL_DONE_o,
               VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Arbitrates the CHR_GEN VRAM write port between a CPU requester and a clear/pattern
// fill engine; writes land only on CK_EE slots (optionally blanking-only) to avoid tearing.
module vram_write_arbiter #(
    parameter int C_AW         = 10,
    parameter int C_DW         = 8,
    parameter int C_DEPTH      = 1024,
    parameter int C_BLANK_ONLY = 1
) (
    input  logic                  CK_i,
    input  logic                  SRST_i,
    vram_write_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic            LP_ANY_SLOT = (C_BLANK_ONLY == 0);
    localparam logic [C_AW:0]   LP_LAST     = (C_AW + 1)'(C_DEPTH - 1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [C_AW:0]   r_addr;
    logic [C_DW-1:0] r_data;
    logic            r_inc;

    logic            r_busy;
    logic            r_done;
    logic            r_ack;
    logic            r_we;
    logic [C_AW-1:0] r_wa;
    logic [C_DW-1:0] r_wd;

    logic            w_slot;
    logic            w_cpu_grant;
    logic            w_fill_grant;
    logic            w_fill_last;
    logic            w_fill_load;

    // A pending ACK masks REQ for one cycle so a held request is not issued twice.
    assign w_slot       = bus.CK_EE_i & (bus.BLANK_i | LP_ANY_SLOT);
    assign w_cpu_grant  = w_slot & bus.CPU_REQ_i & ~r_ack;
    assign w_fill_grant = w_slot & ~w_cpu_grant & (r_state == S_FILL);
    assign w_fill_last  = (r_addr == LP_LAST);
    assign w_fill_load  = (r_state == S_IDLE) & bus.FILL_START_i & ~bus.FILL_ABORT_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fill_load) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.FILL_ABORT_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fill_grant && w_fill_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_FILL);
            r_done  <= (r_state == S_DONE);
            r_ack   <= w_cpu_grant;
        end
    end

    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            r_addr <= '0;
            r_data <= '0;
            r_inc  <= 1'b0;
        end else if (w_fill_load) begin
            r_addr <= '0;
            r_data <= bus.FILL_DATs_i;
            r_inc  <= bus.FILL_INC_i;
        end else if (w_fill_grant) begin
            r_addr <= r_addr + 1'b1;
            r_data <= r_data + {{(C_DW-1){1'b0}}, r_inc};
        end
    end

    // Output port moves only on CK_EE so WE spans exactly one enable period per write.
    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (bus.CK_EE_i) begin
            if (w_cpu_grant) begin
                r_we <= 1'b1;
                r_wa <= bus.CPU_WAs_i;
                r_wd <= bus.CPU_WDs_i;
            end else if (w_fill_grant) begin
                r_we <= 1'b1;
                r_wa <= r_addr[C_AW-1:0];
                r_wd <= r_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.CPU_ACK_o   = r_ack;
    assign bus.FILL_BUSY_o = r_busy;
    assign bus.FILL_DONE_o = r_done;
    assign bus.VRAM_WE_o   = r_we;
    assign bus.VRAM_WAs_o  = r_wa;
    assign bus.VRAM_WDs_o  = r_wd;

endmodule
